// File: rtl/seven_seg_pkg.sv
// Shared constants for the multiplexed seven-segment seconds counter:
// segment patterns {g,f,e,d,c,b,a} (active-high), BCD digit width, counter widths.
package seven_seg_pkg;

   localparam int unsigned BCD_W      = 4;
   localparam int unsigned PRESCALE_W = 24;
   localparam int unsigned SCAN_W     = 16;
   localparam int unsigned SEG_W      = 7;

   localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
   localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
   localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
   localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
   localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
   localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
   localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
   localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
   localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seven_segment_counter_mux_seg7.sv
// BCD to seven-segment decoder {g,f,e,d,c,b,a}; codes 10-15 decode to blank.
module seg7
   import seven_seg_pkg::*;
(
   input  logic [BCD_W-1:0] bcd,
   output logic [SEG_W-1:0] seg_c
);

   always_comb begin
      seg_c = SEG_BLANK;
      case (bcd)
         4'd0:    seg_c = SEG_0;
         4'd1:    seg_c = SEG_1;
         4'd2:    seg_c = SEG_2;
         4'd3:    seg_c = SEG_3;
         4'd4:    seg_c = SEG_4;
         4'd5:    seg_c = SEG_5;
         4'd6:    seg_c = SEG_6;
         4'd7:    seg_c = SEG_7;
         4'd8:    seg_c = SEG_8;
         4'd9:    seg_c = SEG_9;
         default: seg_c = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seven_segment_counter_mux.sv
// Multi-digit BCD up/down seconds counter with time-multiplexed seven-segment drive.
// Optional leading-zero blanking is enabled by defining SEVSEG_LEADING_BLANK_EN.
module seven_segment_counter_mux
   import seven_seg_pkg::*;
#(
   parameter int unsigned           DIGITS     = 4,
   parameter logic [PRESCALE_W-1:0] TICK_COUNT = 24'd10_000_000,
   parameter logic [SCAN_W-1:0]     SCAN_COUNT = 16'd10_000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ena,
   input  logic [7:0]                tick_cfg,
   input  logic                      run,
   input  logic                      up_down,
   input  logic                      clear,
   output logic [BCD_W*DIGITS-1:0]   count_bcd,
   output logic                      wrap,
   output logic [DIGITS-1:0]         digit_sel,
   output logic [SEG_W-1:0]          segments,
   output logic                      dp
);

   localparam int unsigned CNT_W = BCD_W * DIGITS;
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [PRESCALE_W-1:0] prescaler_q, prescaler_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  wrap_q, wrap_d;
   logic                  toggle_q, toggle_d;
   logic [SCAN_W-1:0]     scan_q, scan_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DIGITS-1:0]     digit_sel_q, digit_sel_d;
   logic [SEG_W-1:0]      segments_q, segments_d;
   logic                  dp_q, dp_d;

   logic [PRESCALE_W-1:0] terminal_c;
   logic                  tick_c;
   logic [DIGITS-1:0]     at_lim_c;
   logic [CNT_W-1:0]      stepped_c;
   logic [BCD_W-1:0]      sel_digit_c;
   logic [SEG_W-1:0]      seg_c;
   logic                  blank_c;

   // >= rather than == so a lowered terminal takes effect on the next cycle
   assign terminal_c = (tick_cfg == 8'd0) ? TICK_COUNT : {6'b0, tick_cfg, 10'b0};
   assign tick_c     = run & (prescaler_q >= terminal_c);

   // Each stage steps only when every lower stage sits at its limit (9 up, 0 down)
   for (genvar i = 0; i < DIGITS; i++) begin : g_bcd
      localparam logic [DIGITS-1:0] LOW_MASK = DIGITS'((64'd1 << i) - 64'd1);
      logic [BCD_W-1:0] cur;
      logic [BCD_W-1:0] nxt;
      logic             carry_in;

      assign cur         = count_q[i*BCD_W +: BCD_W];
      assign at_lim_c[i] = up_down ? (cur == 4'd9) : (cur == 4'd0);
      assign carry_in    = ((at_lim_c & LOW_MASK) == LOW_MASK);
      assign nxt         = up_down ? (at_lim_c[i] ? 4'd0 : cur + 4'd1)
                                   : (at_lim_c[i] ? 4'd9 : cur - 4'd1);
      assign stepped_c[i*BCD_W +: BCD_W] = carry_in ? nxt : cur;
   end

   always_comb begin
      sel_digit_c = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) sel_digit_c = count_q[i*BCD_W +: BCD_W];
      end
   end

`ifdef SEVSEG_LEADING_BLANK_EN
   // Blank a position when it and everything above it is zero; digit 0 always shows
   always_comb begin
      blank_c = 1'b0;
      for (int unsigned i = 1; i < DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) blank_c = ((count_q >> (i * BCD_W)) == '0);
      end
   end
`else
   assign blank_c = 1'b0;
`endif

   seg7 u_seg7 (
      .bcd   (sel_digit_c),
      .seg_c (seg_c)
   );

   // Next-state: scan and display path always advance; counter follows clear > tick > hold
   always_comb begin
      prescaler_d = prescaler_q;
      count_d     = count_q;
      wrap_d      = wrap_q;
      toggle_d    = toggle_q;
      scan_d      = scan_q;
      idx_d       = idx_q;
      digit_sel_d = digit_sel_q;
      segments_d  = segments_q;
      dp_d        = dp_q;

      if (ena) begin
         if (scan_q == SCAN_COUNT - SCAN_W'(1)) begin
            scan_d = '0;
            idx_d  = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
         end else begin
            scan_d = scan_q + SCAN_W'(1);
         end

         digit_sel_d = DIGITS'(1) << idx_q;
         segments_d  = blank_c ? SEG_BLANK : seg_c;
         dp_d        = toggle_q & (idx_q == '0);
         wrap_d      = 1'b0;

         if (clear) begin
            count_d     = '0;
            prescaler_d = '0;
         end else begin
            if (run) prescaler_d = tick_c ? '0 : prescaler_q + PRESCALE_W'(1);
            if (tick_c) begin
               count_d  = stepped_c;
               wrap_d   = &at_lim_c;
               toggle_d = ~toggle_q;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prescaler_q <= '0;
         count_q     <= '0;
         wrap_q      <= 1'b0;
         toggle_q    <= 1'b0;
         scan_q      <= '0;
         idx_q       <= '0;
         digit_sel_q <= DIGITS'(1);
         segments_q  <= '0;
         dp_q        <= 1'b0;
      end else begin
         prescaler_q <= prescaler_d;
         count_q     <= count_d;
         wrap_q      <= wrap_d;
         toggle_q    <= toggle_d;
         scan_q      <= scan_d;
         idx_q       <= idx_d;
         digit_sel_q <= digit_sel_d;
         segments_q  <= segments_d;
         dp_q        <= dp_d;
      end
   end

   assign count_bcd = count_q;
   assign wrap      = wrap_q;
   assign digit_sel = digit_sel_q;
   assign segments  = segments_q;
   assign dp        = dp_q;

endmodule

// File: doc/seven_segment_counter_mux.md
# seven_segment_counter_mux

Multi-digit BCD seconds counter with time-multiplexed seven-segment drive, the parametrised successor to the single-digit seconds display. A shared prescaler produces a one-cycle tick; a chain of DIGITS decimal stages counts up or down on each tick; a scan counter rotates a one-hot digit select and presents the matching segment pattern. It sits directly behind the top-level pin wrapper, driving uo_out/uio_out.

## Interface
- DIGITS, 4: number of BCD digits, legal range 1–8
- TICK_COUNT, 24'd10_000_000: default prescaler terminal value (1 s at 10 MHz)
- SCAN_COUNT, 16'd10_000: cycles each digit stays selected (1 ms at 10 MHz)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ena  in  1  global enable; low freezes all state, outputs hold
- tick_cfg  in  8  0 → use TICK_COUNT; else terminal = {6'b0, tick_cfg, 10'b0}
- run  in  1  1 = count on ticks, 0 = pause (prescaler holds)
- up_down  in  1  1 = count up, 0 = count down
- clear  in  1  synchronous clear of counter digits and prescaler
- count_bcd  out  4*DIGITS  current count, digit 0 in bits [3:0]
- wrap  out  1  one-cycle pulse when count wraps (99..9→0 up, 0→99..9 down)
- digit_sel  out  DIGITS  one-hot active-high digit enable
- segments  out  7  segment pattern {g,f,e,d,c,b,a} for selected digit, active-high
- dp  out  1  decimal point for selected digit

## Operation
- Reset values: count_bcd 0, wrap 0, digit_sel 'b1, segments 0, dp 0; prescaler, scan counter, dp toggle all 0.
- Priority per enabled cycle: clear > tick > hold. ena=0 overrides all except reset.
- Prescaler: when run=1, increments each cycle; when prescaler >= terminal, tick=1, prescaler → 0. Period = terminal+1 cycles. The >= compare ensures that lowering tick_cfg mid-count terminates on the next cycle with no 2^24 run-out.
- Counter: on tick, up_down=1 increments digit 0 (9→0 with carry into digit 1, rippled through all digits within one cycle); up_down=0 decrements (0→9 with borrow). The all-9s→all-0s (up) or all-0s→all-9s (down) transition asserts wrap for exactly that cycle.
- clear: digits → 0, prescaler → 0, no wrap, no tick that cycle; dp toggle unchanged.
- dp toggle flips on every tick; dp is driven only while digit 0 is selected (dp = toggle & digit_sel[0]).
- Scan: scan counter counts 0..SCAN_COUNT-1; at terminal it wraps to 0, and the digit index advances with wrap DIGITS-1→0. digit_sel = 1<<index.
- Segments: decoded from count_bcd for the current index, decode 0–9 standard; codes 10–15 unreachable, decode to 0.

## Timing
- tick occurs in cycle N; count_bcd/wrap/dp toggle update at edge N+1.
- digit_sel, segments, dp are all registered from the same index in the same edge, so they are always mutually aligned; one-cycle latency from count change to segment change on the selected digit.
- Enabled cycle 1 after reset release: segments show the '0' pattern (7'h3F) on digit 0.
- Reset asserted mid-operation: all outputs take their reset values immediately (async), independent of clk.

## Configuration
- SEVSEG_LEADING_BLANK_EN defined: digits above the most significant non-zero digit decode to segments=0; digit 0 is never blanked (count 0 shows a single '0'). dp is unaffected.
- Not defined: all DIGITS positions always display, including leading zeros.

## Structure
- Package seven_seg_pkg: 7-bit segment constants for 0–9 and blank, the BCD digit width (4), and the 24-bit prescaler width constant.
- One sub-module: the existing seg7 decoder, instantiated once after the digit mux; the blanking mux sits in this block, not in seg7.
- BCD stage increment/decrement is a generate loop inside this block.

## Test plan
- Reset, DIGITS=4, tick_cfg=1 (terminal 1024), run=1, up_down=1: first count_bcd=16'h0001 exactly 1025 cycles after reset release; count_bcd=16'h0010 after 10 ticks.
- Preload to 16'h9999 via 9999 ticks, one more tick → count_bcd=16'h0000, wrap high exactly one cycle; then up_down=0, next tick → 16'h9999 with wrap pulse.
- clear and tick in the same cycle → count_bcd=0, wrap=0, prescaler restarts from 0; run=0 for 5000 cycles → count unchanged.
- SCAN_COUNT=4: digit_sel sequence 0001,0010,0100,1000,0001 changing every 4 cycles; with count 16'h1234, segments match 4,3,2,1 decode in lockstep; dp only with digit_sel[0].
- With SEVSEG_LEADING_BLANK_EN, count 16'h0040: digits 3 and 2 give segments=0, digit 1 shows '4', digit 0 shows '0'; without the macro, digits 3 and 2 show '0'.
- Prescaler at 20000 with tick_cfg=0, switch to tick_cfg=1 → tick on the next cycle; async reset mid-scan → digit_sel='b1 and segments=0 before the next clk edge.
